// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/forward controller for a 5-stage MIPS pipeline (Tuse/Tnew scheme).
// Optional MDU busy tracking is built in when HAZ_MDU_EN is defined. Revision 1.0.
`timescale 1ns/1ps
`default_nettype none

module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int TNEW_W   = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_rs_used,
  input  logic              d_rt_used,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [REG_AW-1:0] d_wa,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic              md_busy
);

  logic [REG_AW-1:0] e_rs, e_rt, e_wa, m_wa, w_wa;
  logic [TNEW_W-1:0] e_tnew, m_tnew;
  logic              raw_stall;
  logic              md_stall;
  logic              md_busy_int;

  function automatic logic hit(input logic [REG_AW-1:0] src, input logic used,
                               input logic [REG_AW-1:0] wa);
    return used && (src != '0) && (wa == src);
  endfunction

  function automatic logic src_stall(input logic [REG_AW-1:0] src, input logic used,
                                     input logic [TNEW_W-1:0] tuse,
                                     input logic [REG_AW-1:0] ewa, input logic [TNEW_W-1:0] etn,
                                     input logic [REG_AW-1:0] mwa, input logic [TNEW_W-1:0] mtn);
    return (hit(src, used, ewa) && (etn > tuse)) || (hit(src, used, mwa) && (mtn > tuse));
  endfunction

  // Youngest matching stage wins; a not-yet-ready winner yields 0 and the stall covers it.
  function automatic logic [1:0] d_sel(input logic [REG_AW-1:0] src, input logic used,
                                       input logic [REG_AW-1:0] ewa, input logic [TNEW_W-1:0] etn,
                                       input logic [REG_AW-1:0] mwa, input logic [TNEW_W-1:0] mtn,
                                       input logic [REG_AW-1:0] wwa);
    if (hit(src, used, ewa))      return (etn == '0) ? 2'd1 : 2'd0;
    else if (hit(src, used, mwa)) return (mtn == '0) ? 2'd2 : 2'd0;
    else if (hit(src, used, wwa)) return 2'd3;
    else                          return 2'd0;
  endfunction

  function automatic logic [1:0] e_sel(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] mwa, input logic [TNEW_W-1:0] mtn,
                                       input logic [REG_AW-1:0] wwa);
    if (hit(src, 1'b1, mwa) && (mtn == '0)) return 2'd1;
    else if (hit(src, 1'b1, wwa))           return 2'd2;
    else                                    return 2'd0;
  endfunction

  assign raw_stall = src_stall(d_rs, d_rs_used, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew)
                   | src_stall(d_rt, d_rt_used, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew)
                   | md_stall;

  assign stall    = !reset && raw_stall;
  assign md_busy  = !reset && md_busy_int;
  assign fwd_d_rs = reset ? 2'd0 : d_sel(d_rs, d_rs_used, e_wa, e_tnew, m_wa, m_tnew, w_wa);
  assign fwd_d_rt = reset ? 2'd0 : d_sel(d_rt, d_rt_used, e_wa, e_tnew, m_wa, m_tnew, w_wa);
  assign fwd_e_rs = reset ? 2'd0 : e_sel(e_rs, m_wa, m_tnew, w_wa);
  assign fwd_e_rt = reset ? 2'd0 : e_sel(e_rt, m_wa, m_tnew, w_wa);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_rs   <= '0;
      e_rt   <= '0;
      e_wa   <= '0;
      e_tnew <= '0;
      m_wa   <= '0;
      m_tnew <= '0;
      w_wa   <= '0;
    end else begin
      if (raw_stall) begin
        e_rs   <= '0;
        e_rt   <= '0;
        e_wa   <= '0;
        e_tnew <= '0;
      end else begin
        e_rs   <= d_rs;
        e_rt   <= d_rt;
        e_wa   <= d_wa;
        e_tnew <= d_tnew;
      end
      m_wa   <= e_wa;
      m_tnew <= (e_tnew == '0) ? '0 : e_tnew - 1'b1;
      w_wa   <= m_wa;
    end
  end

`ifdef HAZ_MDU_EN
  localparam int CNT_W = $clog2(DIV_LAT + 1);

  logic             e_md_start;
  logic             e_md_div;
  logic [CNT_W-1:0] md_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_md_start <= 1'b0;
      e_md_div   <= 1'b0;
      md_cnt     <= '0;
    end else begin
      e_md_start <= raw_stall ? 1'b0 : d_md_start;
      e_md_div   <= raw_stall ? 1'b0 : d_md_div;
      if (e_md_start)
        md_cnt <= e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
    end
  end

  assign md_busy_int = (md_cnt != '0) || e_md_start;
  assign md_stall    = d_md_use && md_busy_int;
`else
  logic unused_md;
  assign unused_md   = ^{d_md_start, d_md_div, d_md_use};
  assign md_busy_int = 1'b0;
  assign md_stall    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; MDU section follows HAZ_MDU_EN.
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wa;
  logic       d_rs_used, d_rt_used;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_stall;

  hazard_ctrl #(
    .REG_AW(5), .TNEW_W(2), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic rs_u, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic rt_u, input logic [1:0] tu_rt,
                       input logic [4:0] wa, input logic [1:0] tn,
                       input logic mds, input logic mdd, input logic mdu);
    d_rs = rs; d_rs_used = rs_u; d_tuse_rs = tu_rs;
    d_rt = rt; d_rt_used = rt_u; d_tuse_rt = tu_rt;
    d_wa = wa; d_tnew = tn;
    d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    settle();
    chk("rst_stall", stall, 0);
    chk("rst_fwd_d_rs", fwd_d_rs, 0);
    chk("rst_fwd_e_rs", fwd_e_rs, 0);
    chk("rst_md_busy", md_busy, 0);
    tick();
    reset = 1'b0;

    // lw $8 (tnew 2) then add reading $8 at tuse 1
    set_d(29, 1, 1, 0, 0, 0, 8, 2, 0, 0, 0);
    settle(); chk("lw_nostall", stall, 0);
    tick();
    set_d(8, 1, 1, 9, 1, 1, 11, 1, 0, 0, 0);
    settle(); chk("lw_add_stall", stall, 1); chk("lw_add_fwd_notready", fwd_d_rs, 0);
    tick();
    settle(); chk("lw_add_release", stall, 0); chk("lw_add_fwd_m_notready", fwd_d_rs, 0);
    tick();
    nop();
    settle(); chk("lw_add_fwd_e_w", fwd_e_rs, 2); chk("lw_add_fwd_e_rt", fwd_e_rt, 0);
    tick(); tick(); tick();

    // add $9 (tnew 1) then beq $9 (tuse 0)
    set_d(1, 1, 1, 2, 1, 1, 9, 1, 0, 0, 0);
    tick();
    set_d(9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("beq_stall", stall, 1); chk("beq_fwd_e_notready", fwd_d_rs, 0);
    tick();
    settle(); chk("beq_release", stall, 0); chk("beq_fwd_m", fwd_d_rs, 2);
    tick();
    nop(); tick(); tick(); tick();

    // two ori $10 in flight: M copy must win over W copy
    set_d(2, 1, 1, 0, 0, 0, 10, 1, 0, 0, 0);
    tick(); tick();
    nop(); tick();
    set_d(10, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    settle(); chk("ori_fwd_m_wins", fwd_d_rs, 2); chk("ori_nostall", stall, 0);
    chk("reg0_fwd", fwd_d_rt, 0);
    tick();
    set_d(10, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("ori_fwd_d_w", fwd_d_rs, 3); chk("ori_fwd_e_w", fwd_e_rs, 2);
    chk("reg0_fwd_e", fwd_e_rt, 0);
    tick();
    nop(); tick(); tick(); tick();

    // E-stage consumer picks value from M
    set_d(3, 1, 1, 0, 0, 0, 12, 1, 0, 0, 0);
    tick();
    set_d(12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("efwd_nostall", stall, 0); chk("efwd_d_sel", fwd_d_rs, 0);
    tick();
    nop();
    settle(); chk("efwd_m", fwd_e_rs, 1);
    tick(); tick(); tick();

    // producer with tnew 0 forwards straight from E
    set_d(0, 0, 0, 0, 0, 0, 13, 0, 0, 0, 0);
    tick();
    set_d(0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0);
    settle(); chk("tnew0_fwd_e", fwd_d_rt, 1); chk("tnew0_nostall", stall, 0);
    tick();
    nop(); tick(); tick(); tick();

    // asynchronous reset in the middle of a hazard
    set_d(29, 1, 1, 0, 0, 0, 8, 2, 0, 0, 0);
    tick();
    set_d(8, 1, 0, 8, 1, 0, 0, 0, 0, 0, 1);
    settle(); chk("pre_reset_stall", stall, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_stall", stall, 0);
    chk("async_rst_fwd_d_rs", fwd_d_rs, 0);
    chk("async_rst_fwd_d_rt", fwd_d_rt, 0);
    chk("async_rst_md_busy", md_busy, 0);
    tick();
    reset = 1'b0;
    set_d(4, 1, 0, 5, 1, 0, 6, 1, 0, 0, 0);
    settle(); chk("post_rst_stall", stall, 0); chk("post_rst_fwd", fwd_d_rs, 0);
    tick();
    nop(); tick(); tick(); tick();

`ifdef HAZ_MDU_EN
    // div, then mflo right behind it
    set_d(1, 1, 1, 2, 1, 1, 0, 0, 1, 1, 1);
    settle(); chk("div_issue", stall, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 14, 1, 0, 0, 1);
    settle(); chk("div_busy", md_busy, 1);
    n_stall = 0;
    while (stall && n_stall < 40) begin
      n_stall++;
      tick(); settle();
    end
    chk("div_stall_len", n_stall, DIV_LAT + 1);
    chk("div_busy_drop", md_busy, 0);
    tick();
    nop(); tick(); tick(); tick();

    // mult, three unrelated instrs, then mflo
    set_d(1, 1, 1, 2, 1, 1, 0, 0, 1, 0, 1);
    tick();
    nop(); tick(); tick(); tick();
    set_d(0, 0, 0, 0, 0, 0, 14, 1, 0, 0, 1);
    settle();
    n_stall = 0;
    while (stall && n_stall < 40) begin
      n_stall++;
      tick(); settle();
    end
    chk("mult_stall_len", n_stall, MULT_LAT - 2);
    chk("mult_busy_drop", md_busy, 0);
    tick();
`else
    set_d(1, 1, 1, 2, 1, 1, 0, 0, 1, 1, 1);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 14, 1, 0, 0, 1);
    settle(); chk("nomdu_busy", md_busy, 0); chk("nomdu_stall", stall, 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
